// File: rtl/ftdi_tx_buffer_if.sv
// Byte path between inner logic, the TX FIFO and the FTDI write sequencer.
interface ftdi_tx_buffer_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          iTX_DATA;
    logic                iTX_VALID;
    logic                oTX_READY;
    logic [DEPTH_LOG2:0] oTX_COUNT;
    logic                oOVF;
    logic                iOVF_CLR;
    logic                oACT_WR_n;
    logic [7:0]          oWR_DATA;
    logic                iREADY_WR_n;
    logic                iDONE_WR_n;

    modport master (
        output iTX_DATA, iTX_VALID, iOVF_CLR, iREADY_WR_n, iDONE_WR_n,
        input  oTX_READY, oTX_COUNT, oOVF, oACT_WR_n, oWR_DATA
    );

    modport slave (
        input  iTX_DATA, iTX_VALID, iOVF_CLR, iREADY_WR_n, iDONE_WR_n,
        output oTX_READY, oTX_COUNT, oOVF, oACT_WR_n, oWR_DATA
    );
endinterface

// File: rtl/ftdi_tx_buffer.sv
// TX byte FIFO feeding the FTDI write sequencer one byte per
// activate/done handshake, with sticky overflow on dropped pushes.
module ftdi_tx_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    ftdi_tx_buffer_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP
    } state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  ovf;
    logic                  act_n;
    logic                  act_n_nx;
    state_t                state;
    state_t                state_nx;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign full = (count == FULL_CNT);
    assign pop  = (state == WAIT_DONE) && !bus.iDONE_WR_n;
    // A pop on the same edge frees the slot, so a push at full is kept.
    assign push = bus.iTX_VALID && (!full || pop);
    assign drop = bus.iTX_VALID && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.iTX_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (bus.iOVF_CLR) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            act_n <= 1'b1;
        end else begin
            state <= state_nx;
            act_n <= act_n_nx;
        end
    end

    always_comb begin
        state_nx = state;
        act_n_nx = 1'b1;
        unique case (state)
            IDLE: begin
                if (count != '0 && !bus.iREADY_WR_n) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.iDONE_WR_n) begin
                    state_nx = GAP;
                end
            end
            GAP: begin
                // Skip one cycle so a stale ready is never reused.
                state_nx = IDLE;
            end
        endcase
        act_n_nx = (state_nx != ISSUE);
    end

    assign bus.oTX_READY = !full;
    assign bus.oTX_COUNT = count;
    assign bus.oOVF      = ovf;
    assign bus.oACT_WR_n = act_n;
    assign bus.oWR_DATA  = mem[rd_ptr];
endmodule

// File: tb/tb_ftdi_tx_buffer.sv
// Directed + randomized bench for ftdi_tx_buffer with a queue-based
// reference model and a write-sequencer responder.
module tb_ftdi_tx_buffer;
    logic clk = 1'b0;
    logic rst;

    ftdi_tx_buffer_if #(.DEPTH_LOG2(4)) bus ();

    ftdi_tx_buffer #(.DEPTH_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic auto_done_n = 1'b1;
    logic man_done_n  = 1'b1;
    assign bus.iDONE_WR_n = auto_done_n & man_done_n;

    int auto_en = 1;
    int dly     = 1;

    // Reference model: every accepted byte in arrival order.
    logic [7:0] exp_q[$];
    int m_cnt  = 0;
    int m_ovf  = 0;
    int m_infl = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < m_cnt - m_infl; k++) begin
                void'(exp_q.pop_back());
            end
            m_cnt  = 0;
            m_ovf  = 0;
            m_infl = 0;
        end else begin
            int pop_e;
            int ovf_e;
            pop_e = (m_infl != 0 && bus.iDONE_WR_n === 1'b0) ? 1 : 0;
            if (pop_e != 0) m_infl = 0;
            if (bus.oACT_WR_n === 1'b0) m_infl = 1;
            ovf_e = (bus.iTX_VALID && m_cnt == 16 && pop_e == 0) ? 1 : 0;
            if (bus.iTX_VALID && ovf_e == 0) begin
                exp_q.push_back(bus.iTX_DATA);
                m_cnt = m_cnt + 1;
            end
            m_cnt = m_cnt - pop_e;
            if (ovf_e != 0) m_ovf = 1;
            else if (bus.iOVF_CLR) m_ovf = 0;
        end
    end

    // Write-sequencer responder: logs every issued byte.
    logic [7:0] issued[$];
    logic [7:0] pending = 8'h00;
    int armed     = 0;
    int wait_c    = 0;
    int act_prev  = 0;
    int proto_bad = 0;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            auto_done_n = 1'b1;
            armed       = 0;
            act_prev    = 0;
        end else begin
            auto_done_n = 1'b1;
            if (bus.oACT_WR_n === 1'b0) begin
                if (act_prev != 0) proto_bad++;
                issued.push_back(bus.oWR_DATA);
                pending = bus.oWR_DATA;
                armed   = auto_en;
                wait_c  = dly;
            end else if (armed != 0) begin
                if (wait_c == 0) begin
                    if (bus.oWR_DATA !== pending) proto_bad++;
                    auto_done_n = 1'b0;
                    armed = 0;
                end else begin
                    wait_c--;
                end
            end
            act_prev = (bus.oACT_WR_n === 1'b0) ? 1 : 0;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        chk("count", int'(bus.oTX_COUNT), m_cnt);
        chk("ovf", int'(bus.oOVF), m_ovf);
        chk("ready", int'(bus.oTX_READY), (m_cnt < 16) ? 1 : 0);
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while ((m_cnt != 0 || m_infl != 0) && t < budget) begin
            step();
            t++;
        end
        chk("drain_timeout", (m_cnt == 0 && m_infl == 0) ? 1 : 0, 1);
    endtask

    task automatic wait_infl(input int budget);
        int t = 0;
        while (m_infl == 0 && t < budget) begin
            step();
            t++;
        end
        chk("issue_timeout", m_infl, 1);
    endtask

    task automatic push(input logic [7:0] d);
        bus.iTX_VALID = 1'b1;
        bus.iTX_DATA  = d;
        step();
        bus.iTX_VALID = 1'b0;
    endtask

    initial begin
        int base;
        bus.iTX_DATA    = 8'h00;
        bus.iTX_VALID   = 1'b0;
        bus.iOVF_CLR    = 1'b0;
        bus.iREADY_WR_n = 1'b1;
        rst = 1'b0;
        repeat (3) step();
        chk("rst_act", int'(bus.oACT_WR_n), 1);
        chk("rst_count", int'(bus.oTX_COUNT), 0);
        chk("rst_ready", int'(bus.oTX_READY), 1);
        chk("rst_ovf", int'(bus.oOVF), 0);
        rst = 1'b1;
        step();

        // Single byte
        bus.iREADY_WR_n = 1'b0;
        dly = 2;
        base = issued.size();
        push(8'hA5);
        wait_drain(100);
        chk("single_n", issued.size(), base + 1);
        if (issued.size() > base) chk("single_d", int'(issued[base]), 'hA5);
        chk("single_cnt", int'(bus.oTX_COUNT), 0);

        // Fill past full with the sequencer busy
        bus.iREADY_WR_n = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            bus.iTX_VALID = 1'b1;
            bus.iTX_DATA  = 8'(i);
            step();
        end
        bus.iTX_VALID = 1'b0;
        chk("fill_cnt", int'(bus.oTX_COUNT), 16);
        chk("fill_ready", int'(bus.oTX_READY), 0);
        chk("fill_ovf", int'(bus.oOVF), 1);
        base = issued.size();
        bus.iREADY_WR_n = 1'b0;
        dly = 0;
        wait_drain(400);
        chk("fill_n", issued.size(), base + 16);
        for (int i = 0; i < 16 && base + i < issued.size(); i++) begin
            chk("fill_order", int'(issued[base + i]), i);
        end

        // Overflow clear, then clear losing to an overflowing push
        bus.iOVF_CLR = 1'b1;
        step();
        bus.iOVF_CLR = 1'b0;
        chk("clr_ovf", int'(bus.oOVF), 0);
        bus.iREADY_WR_n = 1'b1;
        step();
        step();
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
        bus.iOVF_CLR = 1'b1;
        push(8'h50);
        bus.iOVF_CLR = 1'b0;
        chk("clr_vs_ovf", int'(bus.oOVF), 1);
        bus.iOVF_CLR = 1'b1;
        step();
        bus.iOVF_CLR = 1'b0;
        chk("clr_again", int'(bus.oOVF), 0);

        // Push at full coinciding with a pop
        auto_en = 0;
        base = issued.size();
        bus.iREADY_WR_n = 1'b0;
        wait_infl(50);
        bus.iREADY_WR_n = 1'b1;
        bus.iTX_VALID = 1'b1;
        bus.iTX_DATA  = 8'hEE;
        man_done_n    = 1'b0;
        step();
        bus.iTX_VALID = 1'b0;
        man_done_n    = 1'b1;
        chk("full_pp_cnt", int'(bus.oTX_COUNT), 16);
        chk("full_pp_ovf", int'(bus.oOVF), 0);
        auto_en = 1;
        dly = 1;
        bus.iREADY_WR_n = 1'b0;
        wait_drain(400);
        chk("full_pp_n", issued.size(), base + 17);
        if (issued.size() > 0)
            chk("full_pp_last", int'(issued[issued.size() - 1]), 'hEE);
        if (issued.size() > base + 15)
            chk("full_pp_4f", int'(issued[base + 15]), 'h4F);

        // Reset while waiting for done with 5 bytes stored
        bus.iREADY_WR_n = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        auto_en = 0;
        bus.iREADY_WR_n = 1'b0;
        wait_infl(50);
        bus.iREADY_WR_n = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_wd_act", int'(bus.oACT_WR_n), 1);
        chk("rst_wd_cnt", int'(bus.oTX_COUNT), 0);
        step();
        rst = 1'b1;
        step();
        man_done_n = 1'b0;
        step();
        man_done_n = 1'b1;
        base = issued.size();
        bus.iREADY_WR_n = 1'b0;
        repeat (6) step();
        chk("late_done_cnt", int'(bus.oTX_COUNT), 0);
        chk("late_done_noissue", issued.size(), base);
        auto_en = 1;

        // Wrap: 40 bytes with random push gaps and done latency
        base = issued.size();
        for (int i = 0; i < 40; i++) begin
            int gap;
            int t;
            gap = int'($urandom_range(0, 3));
            repeat (gap) step();
            t = 0;
            while (m_cnt >= 16 && t < 200) begin
                step();
                t++;
            end
            dly = int'($urandom_range(0, 2));
            push(8'(i));
        end
        wait_drain(1000);
        chk("wrap_n", issued.size(), base + 40);
        for (int i = 0; i < 40 && base + i < issued.size(); i++) begin
            chk("wrap_order", int'(issued[base + i]), i);
        end

        // Whole-run sequence against the model
        chk("total_n", issued.size(), exp_q.size());
        for (int i = 0; i < issued.size() && i < exp_q.size(); i++) begin
            chk("total_seq", int'(issued[i]), int'(exp_q[i]));
        end
        chk("protocol", proto_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ftdi_tx_buffer.md
FTDI_TX_BUFFER -- requirements
Module: ftdi_tx_buffer

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, FIFO depth = 2^DEPTH_LOG2 bytes (16).
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 iTX_DATA  input  8  byte from inner logic.
REQ-005 iTX_VALID  input  1  push request, active-high, sampled each clk.
REQ-006 oTX_READY  output  1  high when FIFO not full.
REQ-007 oTX_COUNT  output  DEPTH_LOG2+1  bytes currently stored.
REQ-008 oOVF  output  1  sticky overflow flag.
REQ-009 iOVF_CLR  input  1  clears oOVF, active-high.
REQ-010 oACT_WR_n  output  1  write-sequencer activate, active-low.
REQ-011 oWR_DATA  output  8  byte presented to write sequencer.
REQ-012 iREADY_WR_n  input  1  write sequencer idle/ready, active-low.
REQ-013 iDONE_WR_n  input  1  write sequencer byte-done pulse, active-low, 1 clk wide.

Function
REQ-014 The block SHALL store bytes in a circular FIFO of 2^DEPTH_LOG2 entries with DEPTH_LOG2-bit read/write pointers wrapping modulo depth.
REQ-015 Push SHALL occur on a clk edge with iTX_VALID=1 and count < depth; the byte is written at wr_ptr, wr_ptr increments.
REQ-016 Push with count = depth SHALL drop the byte, leave pointers and count unchanged, and set oOVF on that edge.
REQ-017 oOVF SHALL stay set until an edge with iOVF_CLR=1 and no simultaneous overflow; overflow wins over clear on the same edge.
REQ-018 oTX_READY SHALL equal (count < depth), combinationally from registered count.
REQ-019 oWR_DATA SHALL equal the entry at rd_ptr and remain stable from ISSUE through WAIT_DONE.
REQ-020 Drain FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
REQ-021 IDLE: oACT_WR_n=1; go to ISSUE when count > 0 and iREADY_WR_n=0.
REQ-022 ISSUE: oACT_WR_n=0 for exactly one clk; go to WAIT_DONE unconditionally.
REQ-023 WAIT_DONE: oACT_WR_n=1; iREADY_WR_n ignored; on iDONE_WR_n=0 pop (rd_ptr increments, count decrements) and go to GAP.
REQ-024 GAP: oACT_WR_n=1 for one clk; go to IDLE; guarantees a stale iREADY_WR_n is not used for the next issue.
REQ-025 Simultaneous push and pop on the same edge SHALL leave count unchanged and advance both pointers; a push when full with a pop on the same edge SHALL be accepted (count stays at depth) and SHALL NOT set oOVF.
REQ-026 A byte written into an empty FIFO SHALL be eligible for ISSUE on the following clk at the earliest (push-to-oACT_WR_n low latency minimum 2 clk when sequencer ready).
REQ-027 oACT_WR_n SHALL be registered (glitch-free); never low outside ISSUE.
REQ-028 Sustained throughput SHALL be one byte per sequencer cycle plus ISSUE and GAP overhead; no byte SHALL be issued twice or skipped.

Reset
REQ-029 On rst=0, asynchronously: rd_ptr=0, wr_ptr=0, count=0, oOVF=0, FSM=IDLE, oACT_WR_n=1, oTX_READY=1, oTX_COUNT=0.
REQ-030 FIFO storage SHALL NOT require reset; oWR_DATA is don't-care while count=0.
REQ-031 Reset asserted in ISSUE or WAIT_DONE SHALL discard the in-flight byte and all stored bytes; no oACT_WR_n pulse follows reset release until a new push.

Verification
REQ-032 Single byte: push 0xA5 with sequencer model ready -> one oACT_WR_n low pulse with oWR_DATA=0xA5; after iDONE_WR_n pulse oTX_COUNT=0.
REQ-033 Fill: 17 back-to-back pushes 0x00..0x10, sequencer held busy (iREADY_WR_n=1) -> oTX_COUNT=16, oTX_READY=0, oOVF=1, byte 0x10 dropped; release -> bytes 0x00..0x0F emitted in order.
REQ-034 Wrap: push/drain 40 bytes 0x00..0x27 interleaved with random iTX_VALID gaps -> output sequence identical to input, pointers wrapped twice without loss.
REQ-035 Simultaneous push at full plus pop (iDONE_WR_n=0 same edge) -> oTX_COUNT stays 16, oOVF stays 0, new byte emitted last.
REQ-036 Overflow clear: oOVF=1, pulse iOVF_CLR with no push -> oOVF=0 next edge; iOVF_CLR with overflowing push -> oOVF remains 1.
REQ-037 Reset during WAIT_DONE with 5 bytes stored -> immediately oACT_WR_n=1, oTX_COUNT=0; after release, a late iDONE_WR_n pulse causes no pop and no underflow.
